// File: rtl/contador_m_regressivo_trava.sv
// Modulo-M down-counter that locks at zero, with a one-cycle expiry pulse.
// Q/fim/meio update on the command edge; pulso_fim is registered and overlaps the first fim cycle.
module contador_m_regressivo_trava #(
    parameter int M = 100,
    parameter int N = 7
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         carrega,
    input  logic [N-1:0] valor,
    input  logic         conta,
    output logic [N-1:0] Q,
    output logic         fim,
    output logic         meio,
    output logic         pulso_fim,
    output logic         ocupado,
    output logic [1:0]   estado
);

    localparam logic [N-1:0] MAXV = (N)'(M - 1);
    localparam logic [N-1:0] MEIO = (N)'(M / 2);
    localparam logic [N-1:0] UM   = (N)'(1);

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        TRAVADO  = 2'b10,
        INVALIDO = 2'b11
    } estado_t;

    generate
        if (M < 2 || M > (2 ** N)) begin : g_param_check
            $error("contador_m_regressivo_trava: M must satisfy 2 <= M <= 2**N");
        end
    endgenerate

    estado_t      estado_q;
    logic [N-1:0] cont_q;
    logic         pulso_q;
    logic         ocupado_q;
    logic [N-1:0] carga_d;

    // Out-of-range load values clamp to the preset value.
    always_comb begin
        carga_d = (valor > MAXV) ? MAXV : valor;
    end

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            cont_q    <= MAXV;
            estado_q  <= OCIOSO;
            pulso_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            pulso_q <= 1'b0;
            if (zera_s) begin
                cont_q    <= MAXV;
                estado_q  <= OCIOSO;
                ocupado_q <= 1'b0;
            end else if (carrega) begin
                cont_q    <= carga_d;
                estado_q  <= (carga_d == '0) ? TRAVADO : OCIOSO;
                ocupado_q <= 1'b0;
            end else begin
                case (estado_q)
                    OCIOSO, CONTANDO: begin
                        // Q==0 outside TRAVADO only follows a 11 recovery; hold it there.
                        if (conta && cont_q > UM) begin
                            cont_q    <= cont_q - UM;
                            estado_q  <= CONTANDO;
                            ocupado_q <= 1'b1;
                        end else if (conta && cont_q == UM) begin
                            cont_q    <= '0;
                            estado_q  <= TRAVADO;
                            ocupado_q <= 1'b0;
                            pulso_q   <= 1'b1;
                        end
                    end
                    TRAVADO: begin
                        cont_q    <= '0;
                        ocupado_q <= 1'b0;
                    end
                    default: begin
                        estado_q  <= OCIOSO;
                        ocupado_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q         = cont_q;
    assign fim       = (cont_q == '0);
    assign meio      = (cont_q == MEIO);
    assign pulso_fim = pulso_q;
    assign ocupado   = ocupado_q;
    assign estado    = estado_q;

endmodule

// File: tb/tb_contador_m_regressivo_trava.sv
// Randomized and directed check of contador_m_regressivo_trava against a behavioural countdown model.
module tb_contador_m_regressivo_trava;
    localparam int M = 100;
    localparam int N = 7;

    logic         clock = 1'b0;
    logic         zera_as;
    logic         zera_s;
    logic         carrega;
    logic [N-1:0] valor;
    logic         conta;
    logic [N-1:0] Q;
    logic         fim;
    logic         meio;
    logic         pulso_fim;
    logic         ocupado;
    logic [1:0]   estado;

    contador_m_regressivo_trava #(.M(M), .N(N)) dut (
        .clock(clock), .zera_as(zera_as), .zera_s(zera_s), .carrega(carrega),
        .valor(valor), .conta(conta), .Q(Q), .fim(fim), .meio(meio),
        .pulso_fim(pulso_fim), .ocupado(ocupado), .estado(estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: remaining time, phase (0 idle, 1 counting, 2 locked), expiry pulse.
    int m_q;
    int m_st;
    int m_p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".Q"},         32'(Q),         32'(m_q));
        check({tag, ".fim"},       32'(fim),       32'(m_q == 0));
        check({tag, ".meio"},      32'(meio),      32'(m_q == M / 2));
        check({tag, ".pulso_fim"}, 32'(pulso_fim), 32'(m_p));
        check({tag, ".ocupado"},   32'(ocupado),   32'(m_st == 1));
        check({tag, ".estado"},    32'(estado),    32'(m_st));
    endtask

    task automatic model_edge();
        m_p = 0;
        if (zera_s) begin
            m_q  = M - 1;
            m_st = 0;
        end else if (carrega) begin
            m_q  = (int'(valor) > M - 1) ? M - 1 : int'(valor);
            m_st = (m_q == 0) ? 2 : 0;
        end else if (m_st != 2 && conta) begin
            if (m_q > 1) begin
                m_q  = m_q - 1;
                m_st = 1;
            end else if (m_q == 1) begin
                m_q  = 0;
                m_st = 2;
                m_p  = 1;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic zs, input logic ld, input int v, input logic ct);
        zera_s  = zs;
        carrega = ld;
        valor   = (N)'(v);
        conta   = ct;
    endtask

    // Asserted between edges; outputs must react without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        zera_as = 1'b1;
        #1;
        m_q  = M - 1;
        m_st = 0;
        m_p  = 0;
        check_all(tag);
        zera_as = 1'b0;
    endtask

    initial begin
        zera_as = 1'b1;
        drive(0, 0, 0, 0);
        m_q = M - 1; m_st = 0; m_p = 0;
        #3;
        check_all("reset");
        check("reset_meio_const", 32'(meio), 32'(0));
        zera_as = 1'b0;

        // Load 3 and count down into the lock.
        drive(0, 1, 3, 0); step("t2_load");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1); step("t2_cnt");
            check("t2_pulse", 32'(pulso_fim), 32'(i == 2));
            check("t2_q", 32'(Q), 32'(2 - i));
        end
        check("t2_estado", 32'(estado), 32'(2));
        for (int i = 0; i < 5; i++) begin
            step("t2_locked");
            check("t2_hold0", 32'(Q), 32'(0));
        end

        // Preset, run to the midpoint, then pause.
        drive(1, 0, 0, 0); step("t3_preset");
        drive(0, 0, 0, 1);
        for (int i = 0; i < 49; i++) step("t3_cnt");
        check("t3_q50", 32'(Q), 32'(50));
        check("t3_meio", 32'(meio), 32'(1));
        drive(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("t3_pause");
        check("t3_ocupado", 32'(ocupado), 32'(1));

        // Saturating load and zero load.
        drive(0, 1, 120, 0); step("t4_sat");
        check("t4_q99", 32'(Q), 32'(99));
        drive(0, 1, 0, 0); step("t4_zero");
        check("t4_estado", 32'(estado), 32'(2));
        check("t4_nopulse", 32'(pulso_fim), 32'(0));

        // Priority.
        drive(1, 1, 7, 1); step("t5_zs_wins");
        check("t5_q99", 32'(Q), 32'(99));
        drive(0, 1, 7, 1); step("t5_ld_wins");
        check("t5_q7", 32'(Q), 32'(7));

        // Abort a countdown at 5 with the async reset.
        drive(0, 1, 6, 0); step("t6_load");
        drive(0, 0, 0, 1); step("t6_cnt");
        check("t6_q5", 32'(Q), 32'(5));
        async_reset("t6_arst");
        check("t6_no_pulse", 32'(pulso_fim), 32'(0));
        drive(0, 0, 0, 0); step("t6_after");

        // Random traffic, biased towards short loads so locks happen often.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 40) == 0,
                  $urandom_range(0, 15) == 0,
                  ($urandom_range(0, 1) == 0) ? $urandom_range(0, 8) : $urandom_range(0, 127),
                  $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 250) == 0) async_reset("rnd_arst");
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
